// File: rtl/arb_requester_if.sv
// Handshake bundle between the per-channel requester and its round-robin arbiter.
// The slave modport is the requester's view; master is the driving side.
interface arb_requester_if;
   logic [3:0] push;
   logic [3:0] arb_req;
   logic [1:0] arb_gnt;
   logic       arb_gnt_vld;
   logic       svc_vld;
   logic [1:0] svc_ch;
   logic [3:0] pend_full;
   logic       ovf_err;
   logic       spur_err;
   logic [3:0] starve_err;

   modport slave (
      input  push, arb_gnt, arb_gnt_vld,
      output arb_req, svc_vld, svc_ch, pend_full, ovf_err, spur_err, starve_err
   );

   modport master (
      output push, arb_gnt, arb_gnt_vld,
      input  arb_req, svc_vld, svc_ch, pend_full, ovf_err, spur_err, starve_err
   );
endinterface

// File: rtl/arb_requester.sv
// Four-channel pending-transaction counter feeding a round-robin arbiter.
// Optional starvation watchdog is built when ARB_REQ_STARVE_CHK_EN is defined.
module arb_requester #(
   parameter int DEPTH_W      = 3,
   parameter int STARVE_LIMIT = 8
) (
   input  logic            arb_clk,
   input  logic            arb_rst_n,
   arb_requester_if.slave  bus
);

   localparam logic [DEPTH_W-1:0] CNT_MAX = '1;

   logic [DEPTH_W-1:0] cnt_q [4];
   logic [DEPTH_W-1:0] cnt_d [4];
   logic [3:0]         req_w;
   logic [3:0]         full_w;
   logic [3:0]         gnt_oh;
   logic [3:0]         ovf_hit;
   logic               accept;
   logic               spur_hit;

   logic               svc_vld_q;
   logic [1:0]         svc_ch_q;
   logic               ovf_err_q;
   logic               spur_err_q;

   assign accept   = bus.arb_gnt_vld &&  req_w[bus.arb_gnt];
   assign spur_hit = bus.arb_gnt_vld && !req_w[bus.arb_gnt];

   always_comb begin
      gnt_oh = '0;
      if (accept) gnt_oh[bus.arb_gnt] = 1'b1;
   end

   // A push coinciding with an accepted grant cancels out, even when full.
   for (genvar gi = 0; gi < 4; gi++) begin : gen_ch
      assign req_w[gi]   = (cnt_q[gi] != '0);
      assign full_w[gi]  = (cnt_q[gi] == CNT_MAX);
      assign ovf_hit[gi] = bus.push[gi] && full_w[gi] && !gnt_oh[gi];
      assign cnt_d[gi]   = gnt_oh[gi] ? (bus.push[gi] ? cnt_q[gi] : cnt_q[gi] - DEPTH_W'(1))
                         : (bus.push[gi] && !full_w[gi]) ? cnt_q[gi] + DEPTH_W'(1)
                         : cnt_q[gi];
   end

   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         svc_vld_q  <= 1'b0;
         svc_ch_q   <= 2'd0;
         ovf_err_q  <= 1'b0;
         spur_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         svc_vld_q  <= accept;
         if (accept) svc_ch_q <= bus.arb_gnt;
         ovf_err_q  <= ovf_err_q  | (|ovf_hit);
         spur_err_q <= spur_err_q | spur_hit;
      end
   end

   assign bus.arb_req   = req_w;
   assign bus.pend_full = full_w;
   assign bus.svc_vld   = svc_vld_q;
   assign bus.svc_ch    = svc_ch_q;
   assign bus.ovf_err   = ovf_err_q;
   assign bus.spur_err  = spur_err_q;

`ifdef ARB_REQ_STARVE_CHK_EN
   localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

   logic [WAIT_W-1:0] wait_q [4];
   logic [WAIT_W-1:0] wait_d [4];
   logic [3:0]        starve_hit;
   logic [3:0]        starve_err_q;

   // Waiting is measured on the registered request, so the push cycle itself is free.
   for (genvar gi = 0; gi < 4; gi++) begin : gen_wait
      assign wait_d[gi]     = (!req_w[gi] || gnt_oh[gi]) ? '0
                            : (wait_q[gi] == WAIT_MAX)   ? wait_q[gi]
                            : wait_q[gi] + WAIT_W'(1);
      assign starve_hit[gi] = (wait_d[gi] == WAIT_MAX);
   end

   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         for (int i = 0; i < 4; i++) wait_q[i] <= '0;
         starve_err_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) wait_q[i] <= wait_d[i];
         starve_err_q <= starve_err_q | starve_hit;
      end
   end

   assign bus.starve_err = starve_err_q;
`else
   assign bus.starve_err = 4'b0000;
`endif

endmodule
